// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the unified-memory access controller.
package mem_ctrl_pkg;
    localparam logic [31:0] DATA_BASE = 32'h0000_0100;

    // Word index taken from byte-address bits [7:2]; everything above must be 0
    localparam int IDX_W    = 6;
    localparam int IDX_LO   = 2;
    localparam int IDX_HI   = IDX_LO + IDX_W - 1;
    localparam int RANGE_LO = IDX_HI + 1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        SLOT_DATA  = 1'b0,
        SLOT_FETCH = 1'b1
    } slot_e;
endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check and word-index extraction for one request.
module mem_req_check
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h0,
    parameter bit          CHECK_F3 = 1'b1
) (
    input  logic [31:0]      addr_i,
    input  logic             we_i,
    input  logic [2:0]       funct3_i,
    output logic             ok_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [31:0] off;
    logic        f3_ok;

    assign off   = addr_i - BASE;
    assign idx_o = off[IDX_HI:IDX_LO];

    always_comb begin
        f3_ok = 1'b1;
        if (CHECK_F3) begin
            if (we_i)
                f3_ok = funct3_i inside {F3_SB, F3_SH, F3_SW};
            else
                f3_ok = funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end
    end

    // BASE is word aligned, so the offset's low bits equal the address's
    assign ok_o = f3_ok
                && (off[31:RANGE_LO] == '0)
                && (off[IDX_LO-1:0] == '0);
endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the single memory port between fetch and load/store
// using alternating fetch/data slots.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int n  = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_valid,
    input  logic [31:0]   if_pc,
    output logic          if_ready,
    output logic          if_done,
    output logic [n-1:0]  if_instr,
    output logic          if_err,
    input  logic          d_valid,
    input  logic          d_we,
    input  logic [2:0]    d_funct3,
    input  logic [31:0]   d_addr,
    input  logic [n-1:0]  d_wdata,
    output logic          d_ready,
    output logic          d_done,
    output logic [n-1:0]  d_rdata,
    output logic          d_err,
    output logic          mem_clkdiv2,
    output logic          mem_MemRead,
    output logic          mem_MemWrite,
    output logic [AW-1:0] mem_addr,
    output logic [2:0]    mem_funct3,
    output logic [n-1:0]  mem_data_in,
    input  logic [n-1:0]  mem_data_out
);
    slot_e            phase_q, phase_d;
    logic             f_pend_q, f_pend_d;
    logic             d_pend_q, d_pend_d;
    logic [IDX_W-1:0] iidx_q, iidx_d;
    logic [IDX_W-1:0] didx_q, didx_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [n-1:0]     wdata_q, wdata_d;
    logic             if_done_q, if_done_d;
    logic             if_err_q, if_err_d;
    logic [n-1:0]     if_instr_q, if_instr_d;
    logic             d_done_q, d_done_d;
    logic             d_err_q, d_err_d;
    logic [n-1:0]     d_rdata_q, d_rdata_d;

    logic             f_ok, d_ok;
    logic [IDX_W-1:0] f_idx, d_idx;
    logic             f_slot, d_slot;

    mem_req_check #(.BASE(32'h0), .CHECK_F3(1'b0)) u_f_chk (
        .addr_i   (if_pc),
        .we_i     (1'b0),
        .funct3_i (3'b000),
        .ok_o     (f_ok),
        .idx_o    (f_idx)
    );

    mem_req_check #(.BASE(DATA_BASE), .CHECK_F3(1'b1)) u_d_chk (
        .addr_i   (d_addr),
        .we_i     (d_we),
        .funct3_i (d_funct3),
        .ok_o     (d_ok),
        .idx_o    (d_idx)
    );

    assign f_slot = (phase_q == SLOT_FETCH) && f_pend_q;
    assign d_slot = (phase_q == SLOT_DATA) && d_pend_q;

    always_comb begin
        phase_d    = (phase_q == SLOT_DATA) ? SLOT_FETCH : SLOT_DATA;
        f_pend_d   = f_pend_q;
        d_pend_d   = d_pend_q;
        iidx_d     = iidx_q;
        didx_d     = didx_q;
        we_d       = we_q;
        f3_d       = f3_q;
        wdata_d    = wdata_q;
        if_done_d  = 1'b0;
        if_err_d   = 1'b0;
        if_instr_d = if_instr_q;
        d_done_d   = 1'b0;
        d_err_d    = 1'b0;
        d_rdata_d  = d_rdata_q;

        if (f_slot) begin
            if_instr_d = mem_data_out;
            f_pend_d   = 1'b0;
            if_done_d  = 1'b1;
        end
        if (if_valid && if_ready) begin
            if (f_ok) begin
                f_pend_d = 1'b1;
                iidx_d   = f_idx;
            end else begin
                if_done_d = 1'b1;
                if_err_d  = 1'b1;
            end
        end

        if (d_slot) begin
            d_rdata_d = we_q ? '0 : mem_data_out;
            d_pend_d  = 1'b0;
            d_done_d  = 1'b1;
        end
        // Illegal requests never reach the memory, so no word is clobbered
        if (d_valid && d_ready) begin
            if (d_ok) begin
                d_pend_d = 1'b1;
                didx_d   = d_idx;
                we_d     = d_we;
                f3_d     = d_funct3;
                wdata_d  = d_wdata;
            end else begin
                d_done_d  = 1'b1;
                d_err_d   = 1'b1;
                d_rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= SLOT_DATA;
            f_pend_q   <= 1'b0;
            d_pend_q   <= 1'b0;
            iidx_q     <= '0;
            didx_q     <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            wdata_q    <= '0;
            if_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            if_instr_q <= '0;
            d_done_q   <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            phase_q    <= phase_d;
            f_pend_q   <= f_pend_d;
            d_pend_q   <= d_pend_d;
            iidx_q     <= iidx_d;
            didx_q     <= didx_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            wdata_q    <= wdata_d;
            if_done_q  <= if_done_d;
            if_err_q   <= if_err_d;
            if_instr_q <= if_instr_d;
            d_done_q   <= d_done_d;
            d_err_q    <= d_err_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_ready     = ~f_pend_q;
    assign d_ready      = ~d_pend_q;
    assign if_done      = if_done_q;
    assign if_err       = if_err_q;
    assign if_instr     = if_instr_q;
    assign d_done       = d_done_q;
    assign d_err        = d_err_q;
    assign d_rdata      = d_rdata_q;
    assign mem_clkdiv2  = (phase_q == SLOT_FETCH);
    assign mem_MemRead  = d_slot & ~we_q;
    assign mem_MemWrite = d_slot & we_q;
    assign mem_addr     = {didx_q, iidx_q};
    assign mem_funct3   = f3_q;
    assign mem_data_in  = d_slot ? wdata_q : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural unified memory.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_ready, if_done, if_err;
    logic [31:0] if_instr;
    logic        d_valid = 1'b0, d_we = 1'b0;
    logic [2:0]  d_funct3 = '0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_ready, d_done, d_err;
    logic [31:0] d_rdata;
    logic        mem_clkdiv2, mem_MemRead, mem_MemWrite;
    logic [11:0] mem_addr;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_pc(if_pc), .if_ready(if_ready),
        .if_done(if_done), .if_instr(if_instr), .if_err(if_err),
        .d_valid(d_valid), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_clkdiv2(mem_clkdiv2), .mem_MemRead(mem_MemRead),
        .mem_MemWrite(mem_MemWrite), .mem_addr(mem_addr),
        .mem_funct3(mem_funct3), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Behavioural memory: combinational read, write on posedge
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    bit          mem_init = 1'b0;
    int          cyc = 0, rd_cnt = 0, wr_cnt = 0, slot_bad = 0;

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = '0;
        imem[1] = 32'h0000_2083;
        imem[2] = 32'h0040_2103;
    end

    function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b101:  return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always_comb begin
        mem_data_out = '0;
        if (mem_clkdiv2) mem_data_out = imem[mem_addr[5:0]];
        else mem_data_out = rd_fmt(dmem[mem_addr[11:6]], mem_funct3);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_MemRead) rd_cnt <= rd_cnt + 1;
        if ((mem_MemRead | mem_MemWrite) && mem_clkdiv2) slot_bad <= slot_bad + 1;
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) dmem[i] <= '0;
            dmem[0] <= 32'd17;
            dmem[1] <= 32'd9;
            dmem[3] <= 32'hAABB_CCDD;
            mem_init <= 1'b1;
        end else if (mem_MemWrite) begin
            wr_cnt <= wr_cnt + 1;
            case (mem_funct3)
                3'b000:  dmem[mem_addr[11:6]][7:0]  <= mem_data_in[7:0];
                3'b001:  dmem[mem_addr[11:6]][15:0] <= mem_data_in[15:0];
                default: dmem[mem_addr[11:6]]       <= mem_data_in;
            endcase
        end
    end

    // Scoreboard
    typedef struct packed {
        logic        err;
        logic [31:0] val;
    } exp_t;
    exp_t dq[$];
    exp_t fq[$];
    exp_t de, fe;
    int   d_done_cyc = 0, f_done_cyc = 0, f_acc_cyc = 0;

    always @(negedge clk) begin
        if (rst_n && d_done) begin
            d_done_cyc = cyc;
            if (dq.size() == 0) chk("d_unexpected_done", 32'd1, 32'd0);
            else begin
                de = dq.pop_front();
                chk("d_err", {31'b0, d_err}, {31'b0, de.err});
                chk("d_rdata", d_rdata, de.val);
            end
        end
        if (rst_n && if_done) begin
            f_done_cyc = cyc;
            if (fq.size() == 0) chk("if_unexpected_done", 32'd1, 32'd0);
            else begin
                fe = fq.pop_front();
                chk("if_err", {31'b0, if_err}, {31'b0, fe.err});
                if (!fe.err) chk("if_instr", if_instr, fe.val);
            end
        end
    end

    task automatic send_f(input logic [31:0] pc, input logic eerr, input logic [31:0] ev);
        int t = 0;
        @(negedge clk);
        if_valid = 1'b1;
        if_pc    = pc;
        while (!if_ready && t < 20) begin @(negedge clk); t++; end
        chk("if_ready_to", {31'b0, if_ready}, 32'd1);
        @(posedge clk);
        fq.push_back('{err: eerr, val: ev});
        @(negedge clk);
        if_valid  = 1'b0;
        f_acc_cyc = cyc;
    endtask

    task automatic send_d(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic eerr, input logic [31:0] ev,
                          input bit push);
        int t = 0;
        @(negedge clk);
        d_valid  = 1'b1;
        d_we     = we;
        d_funct3 = f3;
        d_addr   = a;
        d_wdata  = wd;
        while (!d_ready && t < 20) begin @(negedge clk); t++; end
        chk("d_ready_to", {31'b0, d_ready}, 32'd1);
        @(posedge clk);
        if (push) dq.push_back('{err: eerr, val: ev});
        @(negedge clk);
        d_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((dq.size() != 0 || fq.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", {31'b0, (dq.size() == 0 && fq.size() == 0)}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    int r0, w0, gap;

    initial begin
        #12;
        chk("rst_done", {if_done, d_done, if_err, d_err}, 4'b0);
        chk("rst_mem_en", {mem_MemRead, mem_MemWrite, mem_clkdiv2}, 3'b0);
        chk("rst_instr_rdata", if_instr | d_rdata, 32'd0);
        chk("rst_addr_f3", {mem_addr, mem_funct3}, 15'd0);
        chk("rst_data_in", mem_data_in, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rel_ready", {if_ready, d_ready}, 2'b11);
        chk("first_slot_data", {31'b0, mem_clkdiv2}, 32'd0);
        #5;
        chk("phase_toggle", {31'b0, mem_clkdiv2}, 32'd1);

        send_f(32'h4, 1'b0, 32'h0000_2083);
        drain();
        gap = f_done_cyc - f_acc_cyc;
        chk("if_latency", {31'b0, (gap >= 1 && gap <= 2)}, 32'd1);
        chk("fetch_no_write", wr_cnt, 32'd0);

        r0 = rd_cnt;
        send_d(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'd17, 1'b1);
        drain();
        send_d(1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 32'd9, 1'b1);
        drain();
        chk("lw_read_cycles", rd_cnt - r0, 32'd2);

        w0 = wr_cnt;
        send_d(1'b1, 3'b000, 32'h10C, 32'h1234_5611, 1'b0, 32'h0, 1'b1);
        drain();
        chk("sb_write_cycles", wr_cnt - w0, 32'd1);
        send_d(1'b0, 3'b100, 32'h10C, 32'h0, 1'b0, 32'h11, 1'b1);
        drain();

        r0 = rd_cnt;
        w0 = wr_cnt;
        send_d(1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1);
        send_d(1'b1, 3'b010, 32'h102, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
        send_d(1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 32'h0, 1'b1);
        send_f(32'h102, 1'b1, 32'h0);
        drain();
        chk("illegal_no_access", (rd_cnt - r0) + (wr_cnt - w0), 32'd0);

        fork
            send_f(32'h8, 1'b0, 32'h0040_2103);
            send_d(1'b0, 3'b001, 32'h104, 32'h0, 1'b0, 32'd9, 1'b1);
        join
        drain();
        gap = f_done_cyc - d_done_cyc;
        chk("simul_gap", {31'b0, (gap == 1 || gap == -1)}, 32'd1);

        w0 = wr_cnt;
        send_d(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", {mem_MemWrite, mem_MemRead, d_done, if_done}, 4'b0);
        chk("midrst_regs", if_instr | d_rdata | mem_data_in, 32'd0);
        chk("midrst_addr", {20'b0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_no_write", wr_cnt - w0, 32'd0);
        send_d(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'd17, 1'b1);
        drain();

        chk("slot_violations", slot_bad, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
